mc_mem_sequencer: RTL and testbench

- Initiator side of the multicycle unified instruction/data memory.
- Sits between the multicycle controller/datapath and the word-only memory (Address, WriteData, MemRead, MemWrite, ReadData).
- Turns core requests (byte/half/word, load/store, signed/unsigned) into word accesses:
  - extracts and sign- or zero-extends load data;
  - performs read-modify-write for sub-word stores;
  - flags misaligned or out-of-range accesses.

---
 rtl/mc_mem_pkg.sv | 31 +++
 rtl/mc_mem_lane.sv | 38 +++
 rtl/mc_mem_sequencer.sv | 141 ++++++++++++++
 tb/tb_mc_mem_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// Shared encodings and helpers for the multicycle memory sequencer.
package mc_mem_pkg;

    localparam int DATA_W = 32;

    // Access size encodings as presented on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Natural alignment check; the illegal size is never aligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = (addr_lo[0] == 1'b0);
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_mem_lane.sv
// Byte-lane logic: load extract/extend and sub-word store merge (little-endian).
module mc_mem_lane
    import mc_mem_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merged_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Select the addressed lane and extend it to a full word
    always_comb begin
        lane_b = word_i[{off_i, 3'b000} +: 8];
        lane_h = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            SZ_BYTE: load_o = uns_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: load_o = uns_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_o = word_i;
        endcase
    end

    // Replace the target lane(s) of the old word with the low store bits
    always_comb begin
        merged_o = word_i;
        case (size_i)
            SZ_BYTE: merged_o[{off_i, 3'b000} +: 8]  = wdata_i[7:0];
            SZ_HALF: merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mc_mem_sequencer.sv
// Initiator side of the unified multicycle memory: turns byte/half/word
// load/store requests into single-cycle word accesses.
// Handshake: a request is taken at a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE; the response is a one-cycle rsp_valid pulse
// with no backpressure.
module mc_mem_sequencer
    import mc_mem_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MEM_WORDS = 128
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] WriteData,
    output logic             MemRead,
    output logic             MemWrite,
    input  logic [WIDTH-1:0] ReadData
);

    localparam logic [WIDTH-1:0] MEM_LIMIT = WIDTH'(MEM_WORDS);

    state_t           state_q, state_d;
    logic             wr_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic             err_q;
    logic [WIDTH-1:0] merge_q;
    logic [WIDTH-1:0] rdata_q;

    logic             req_err;
    logic [WIDTH-1:0] lane_load;
    logic [WIDTH-1:0] lane_merged;

    // Misaligned, illegal size or beyond the implemented words
    assign req_err = !is_aligned(req_size, req_addr[1:0])
                   || (WIDTH'(req_addr[WIDTH-1:2]) >= MEM_LIMIT);

    mc_mem_lane u_lane (
        .word_i   (ReadData),
        .wdata_i  (wdata_q),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .load_o   (lane_load),
        .merged_o (lane_merged)
    );

    // State register plus latched request, merge word and load result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_valid) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                merge_q <= req_wdata;  // word stores write this unchanged
                rdata_q <= '0;         // stores and errors answer with zero
            end
            if (state_q == ST_RD) begin
                if (wr_q) merge_q <= lane_merged;
                else      rdata_q <= lane_load;
            end
        end
    end

    // Next-state: errors skip memory, word stores skip the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                             state_d = ST_RESP;
                    else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
                    else                                     state_d = ST_RD;
                end
            end
            ST_RD:   state_d = wr_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state outputs; MemWrite is gated so a reset edge never commits a write
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        Address   = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_RD: begin
                MemRead = 1'b1;
                Address = {addr_q[WIDTH-1:2], 2'b00};
            end
            ST_WR: begin
                MemWrite  = reset_n;
                Address   = {addr_q[WIDTH-1:2], 2'b00};
                WriteData = merge_q;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_mem_sequencer.sv
// Directed bench for mc_mem_sequencer with a word memory model and a
// scoreboard monitor that checks each response against queued expectations.
module tb_mc_mem_sequencer;
    import mc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wd;
    } exp_t;
    exp_t exp_q[$];

    // memory model: combinational read, write on rising edge, preload port
    logic [31:0] mem [0:127];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always #5 clk = ~clk;

    assign ReadData = (Address[31:9] == 23'h0) ? mem[Address[8:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (MemWrite) mem[Address[8:2]] <= WriteData;
    end

    mc_mem_sequencer #(.WIDTH(32), .MEM_WORDS(128)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ReadData     (ReadData)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [6:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
    endtask

    task automatic push(input logic [31:0] rd, input logic err, input int lat,
                        input int nrd, input int nwr, input logic [31:0] wd);
        exp_t e;
        e.rdata = rd; e.err = err; e.lat = lat; e.nrd = nrd; e.nwr = nwr; e.wd = wd;
        exp_q.push_back(e);
    endtask

    // one request, then the expectation for its response
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rd, input logic e_err, input int e_lat,
                         input int e_nrd, input int e_nwr, input logic [31:0] e_wd);
        @(posedge clk); #1;
        set_req(wr, sz, uns, addr, wd);
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        push(e_rd, e_err, e_lat, e_nrd, e_nwr, e_wd);
        drain();
    endtask

    // monitor: enable checks every cycle, pops the scoreboard on each response
    int          k = 0;
    int          acc_k = 0;
    int          nrd = 0;
    int          nwr = 0;
    logic [31:0] mon_addr = '0;
    logic [31:0] last_wd = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            k++;
            if (!reset_n) begin
                nrd = 0;
                nwr = 0;
            end else begin
                if (MemRead) begin
                    nrd++;
                    chk("rd_addr", Address, mon_addr);
                    chk("en_excl", {31'h0, MemWrite}, 32'h0);
                end
                if (MemWrite) begin
                    nwr++;
                    last_wd = WriteData;
                    chk("wr_addr", Address, mon_addr);
                end
                if (req_ready)
                    chk("ready_idle", {29'h0, MemRead, MemWrite, rsp_valid}, 32'h0);
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                        chk("latency", 32'(k - acc_k), 32'(e.lat));
                        chk("n_memread", 32'(nrd), 32'(e.nrd));
                        chk("n_memwrite", 32'(nwr), 32'(e.nwr));
                        if (e.nwr > 0) chk("writedata", last_wd, e.wd);
                    end
                end
                if (req_valid && req_ready) begin
                    acc_k = k;
                    nrd = 0;
                    nwr = 0;
                    mon_addr = {req_addr[31:2], 2'b00};
                end
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_flags"}, {28'h0, rsp_valid, rsp_err, MemRead, MemWrite}, 32'h0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_addr"}, Address, 32'h0);
        chk({tag, "_wdata"}, WriteData, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0;
        set_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 128; i++) preload(7'(i), 32'h0);
        preload(7'h10, 32'h8899AABB);
        preload(7'h11, 32'h11223344);
        preload(7'h12, 32'h55667788);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("reset");

        // loads from the preloaded word
        issue(0, SZ_WORD, 0, 32'h40, 32'h0, 32'h8899AABB, 0, 2, 1, 0, 32'h0);
        issue(0, SZ_BYTE, 0, 32'h43, 32'h0, 32'hFFFFFF88, 0, 2, 1, 0, 32'h0);
        issue(0, SZ_BYTE, 1, 32'h41, 32'h0, 32'h000000AA, 0, 2, 1, 0, 32'h0);
        issue(0, SZ_HALF, 0, 32'h42, 32'h0, 32'hFFFF8899, 0, 2, 1, 0, 32'h0);
        issue(0, SZ_HALF, 1, 32'h40, 32'h0, 32'h0000AABB, 0, 2, 1, 0, 32'h0);

        // sub-word and word stores, each followed by a read-back
        issue(1, SZ_BYTE, 0, 32'h42, 32'h12345678, 32'h0, 0, 3, 1, 1, 32'h8878AABB);
        issue(0, SZ_WORD, 0, 32'h40, 32'h0, 32'h8878AABB, 0, 2, 1, 0, 32'h0);
        issue(1, SZ_WORD, 0, 32'h44, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF);
        issue(1, SZ_HALF, 0, 32'h46, 32'h00001234, 32'h0, 0, 3, 1, 1, 32'h1234BEEF);
        issue(0, SZ_HALF, 0, 32'h46, 32'h0, 32'h00001234, 0, 2, 1, 0, 32'h0);

        // error cases: one-cycle response, no memory enables
        issue(0, SZ_HALF, 0, 32'h41, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        issue(1, SZ_WORD, 0, 32'h42, 32'hFFFFFFFF, 32'h0, 1, 1, 0, 0, 32'h0);
        issue(0, SZ_ILL, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        issue(0, SZ_WORD, 0, 32'h200, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0);
        @(negedge clk);
        chk("mem_after_err", mem[7'h10], 32'h8878AABB);

        // reset while the halfword store is in its write cycle
        preload(7'h10, 32'h8899AABB);
        @(posedge clk); #1;
        set_req(1'b1, SZ_HALF, 1'b0, 32'h40, 32'h0000CAFE);
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        chk("mem_after_reset", mem[7'h10], 32'h8899AABB);
        issue(0, SZ_WORD, 0, 32'h40, 32'h0, 32'h8899AABB, 0, 2, 1, 0, 32'h0);

        // back-to-back loads with req_valid held high
        @(posedge clk); #1;
        set_req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        push(32'h8899AABB, 0, 2, 1, 0, 32'h0);
        req_addr = 32'h44;
        wait_ready();
        @(posedge clk); #1;
        push(32'h1234BEEF, 0, 2, 1, 0, 32'h0);
        req_addr = 32'h48;
        wait_ready();
        @(posedge clk); #1;
        push(32'h55667788, 0, 2, 1, 0, 32'h0);
        req_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
